// File: rtl/dmem_nb_pkg.sv
// Shared types and helpers for the non-blocking data memory.
// The payload widths here must match the NB_COL/COL_WIDTH/TAG_WIDTH values used on dmem_nb_pipe.
package dmem_nb_pkg;

  localparam int unsigned DFLT_COL_WIDTH = 8;
  localparam int unsigned DFLT_NB_COL    = 4;
  localparam int unsigned DFLT_TAG_WIDTH = 5;
  localparam int unsigned W              = DFLT_NB_COL * DFLT_COL_WIDTH;

  typedef struct packed {
    logic [W-1:0]              data;
    logic [DFLT_TAG_WIDTH-1:0] tag;
    logic                      oor;
  } rsp_t;

  // Expand per-column write enables to a full-word bit mask.
  function automatic logic [W-1:0] col_mask(input logic [DFLT_NB_COL-1:0] we);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(DFLT_NB_COL); i++) begin
      m[i*DFLT_COL_WIDTH +: DFLT_COL_WIDTH] = {DFLT_COL_WIDTH{we[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// Load-response FIFO with a registered head. There is no full flag: the
// credit counter upstream guarantees a free slot for every push.
module dmem_rsp_fifo
  import dmem_nb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic push,
  input  rsp_t push_data,
  input  logic pop,
  output rsp_t head,
  output logic not_empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  rsp_t            store [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;

  // Storage is reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) store[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  assign head      = store[rd_ptr];
  assign not_empty = (count != '0);

endmodule

// File: rtl/dmem_nb_pipe.sv
// Non-blocking byte-column data memory: one load/store per cycle, in-order
// tagged load responses after RD_LAT cycles, flushable speculative loads.
module dmem_nb_pipe
  import dmem_nb_pkg::*;
#(
  parameter int unsigned SIZE       = 1024,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned COL_WIDTH  = DFLT_COL_WIDTH,
  parameter int unsigned NB_COL     = DFLT_NB_COL,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned RSP_DEPTH  = 4,
  parameter int unsigned TAG_WIDTH  = DFLT_TAG_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [NB_COL-1:0]         req_we,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [NB_COL*COL_WIDTH-1:0] req_wdata,
  input  logic [TAG_WIDTH-1:0]      req_tag,
  input  logic                      flush,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [NB_COL*COL_WIDTH-1:0] rsp_rdata,
  output logic [TAG_WIDTH-1:0]      rsp_tag,
  output logic                      rsp_oor
);

  localparam int unsigned WW = NB_COL * COL_WIDTH;
  localparam int unsigned IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned OW = $clog2(RSP_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] SIZE_L  = (ADDR_WIDTH+1)'(SIZE);
  localparam logic [OW-1:0]       DEPTH_L = OW'(RSP_DEPTH);

  logic [WW-1:0] mem [SIZE];

  logic          acc;
  logic          load_acc;
  logic          store_acc;
  logic          in_range;
  logic [IW-1:0] idx;
  logic [WW-1:0] rd_word;
  logic [WW-1:0] wmask;
  rsp_t          rd_rsp;
  logic          push;
  rsp_t          push_rsp;
  rsp_t          head;
  logic          head_vld;
  logic          rsp_hs;
  logic [OW-1:0] occ_q;

  // Credits come from the registered count: a response pop frees its slot
  // from the next cycle on, which keeps rsp_ready off the req_ready path.
  assign req_ready = !flush && (occ_q < DEPTH_L);
  assign acc       = req_valid && req_ready;
  assign load_acc  = acc && (req_we == '0);
  assign store_acc = acc && (req_we != '0);

  assign in_range = {1'b0, req_addr} < SIZE_L;
  assign idx      = IW'(req_addr);
  assign rd_word  = in_range ? mem[idx] : '0;
  assign wmask    = col_mask(req_we);

  always_comb begin
    rd_rsp      = '0;
    rd_rsp.data = rd_word;
    rd_rsp.tag  = req_tag;
    rd_rsp.oor  = !in_range;
  end

  // Column-masked store; out-of-range stores are dropped.
  always_ff @(posedge clk) begin
    if (store_acc && in_range) mem[idx] <= (rd_word & ~wmask) | (req_wdata & wmask);
  end

  if (RD_LAT == 1) begin : g_lat1
    assign push     = load_acc;
    assign push_rsp = rd_rsp;
  end else begin : g_pipe
    localparam int unsigned NS = RD_LAT - 1;
    logic vld_q [NS];
    rsp_t rsp_q [NS];

    for (genvar s = 0; s < int'(NS); s++) begin : g_stg
      logic vin;
      rsp_t rin;
      if (s == 0) begin : g_first
        assign vin = load_acc;
        assign rin = rd_rsp;
      end else begin : g_next
        assign vin = vld_q[s-1];
        assign rin = rsp_q[s-1];
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld_q[s] <= 1'b0;
          rsp_q[s] <= '0;
        end else begin
          vld_q[s] <= vin && !flush;
          rsp_q[s] <= rin;
        end
      end
    end

    assign push     = vld_q[NS-1];
    assign push_rsp = rsp_q[NS-1];
  end

  dmem_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (flush),
    .push      (push),
    .push_data (push_rsp),
    .pop       (rsp_hs),
    .head      (head),
    .not_empty (head_vld)
  );

  assign rsp_valid = head_vld && !flush;
  assign rsp_hs    = rsp_valid && rsp_ready;
  assign rsp_rdata = head.data;
  assign rsp_tag   = head.tag;
  assign rsp_oor   = head.oor;

  // Outstanding loads: pipeline plus FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   occ_q <= '0;
    else if (flush) occ_q <= '0;
    else            occ_q <= occ_q + OW'(load_acc) - OW'(rsp_hs);
  end

endmodule

// File: tb/tb_dmem_nb_pipe.sv
// Scoreboard bench for dmem_nb_pipe: the driver queues expected load
// responses, an independent monitor pops and compares on each handshake.
module tb_dmem_nb_pipe;

  localparam int unsigned RD_LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_we = '0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_tag = '0;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_tag;
  logic        rsp_oor;

  dmem_nb_pipe #(
    .SIZE       (1000),
    .ADDR_WIDTH (10),
    .COL_WIDTH  (8),
    .NB_COL     (4),
    .RD_LAT     (RD_LAT),
    .RSP_DEPTH  (4),
    .TAG_WIDTH  (5)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_tag   (req_tag),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_tag   (rsp_tag),
    .rsp_oor   (rsp_oor)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        oor;
    int          acc;
    bit          chk;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_wait = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [31:0] sval(input int i);
    return 32'hC0DE_0000 + 32'(i * 17);
  endfunction

  // Monitor: compare each response handshake against the scoreboard head.
  logic        stall_prev = 1'b0;
  logic [37:0] prev_head = '0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got tag %0d data 0x%0h, expected no response", rsp_tag, rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", 64'(rsp_rdata), 64'(e.data));
          check("rsp_tag",  64'(rsp_tag),   64'(e.tag));
          check("rsp_oor",  64'(rsp_oor),   64'(e.oor));
          if (e.chk) check("rsp_latency", 64'(cyc), 64'(e.acc + int'(RD_LAT)));
        end
      end
      if (rsp_valid && !rsp_ready && stall_prev)
        check("rsp_stable", 64'({rsp_rdata, rsp_tag, rsp_oor}), 64'(prev_head));
      stall_prev = rsp_valid && !rsp_ready;
      prev_head  = {rsp_rdata, rsp_tag, rsp_oor};
    end
  end

  // Present one request and hold it until accepted (bounded).
  task automatic send(input logic [3:0] we, input logic [9:0] addr, input logic [31:0] wd,
                      input logic [4:0] tag, input logic [31:0] ed, input logic eo, input bit chk);
    exp_t e;
    int   waits = 0;
    bit   done = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_tag   = tag;
    while (!done) begin
      @(negedge clk);
      if (req_ready) begin
        if (we == 4'b0000) begin
          e.data = ed; e.tag = tag; e.oor = eo; e.acc = cyc; e.chk = chk;
          exp_q.push_back(e);
        end
        last_wait = waits;
        done = 1;
      end else if (waits >= 50) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: request addr %0d tag %0d not accepted, expected acceptance", addr, tag);
        last_wait = waits;
        done = 1;
      end
      waits++;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_tag",   64'(rsp_tag),   64'd0);
    check("rst_rsp_oor",   64'(rsp_oor),   64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // Byte-enable store merge
    rsp_ready = 1'b1;
    send(4'b1111, 10'd5, 32'hAABB_CCDD, 5'd0, 32'h0, 1'b0, 1'b0);
    send(4'b0101, 10'd5, 32'h1122_3344, 5'd0, 32'h0, 1'b0, 1'b0);
    send(4'b0000, 10'd5, 32'h0, 5'd3, 32'hAA22_CC44, 1'b0, 1'b1);
    drain("be_drain");

    // Streaming loads, one response per cycle
    for (int i = 0; i < 16; i++) send(4'b1111, 10'(i), sval(i), 5'd0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send(4'b0000, 10'(i), 32'h0, 5'(i), sval(i), 1'b0, 1'b1);
      check("stream_ready", 64'(last_wait), 64'd0);
    end
    drain("stream_drain");

    // Back-pressure: four credits, then stall
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(4'b0000, 10'(i), 32'h0, 5'(20 + i), sval(i), 1'b0, 1'b0);
      check("bp_accept", 64'(last_wait), 64'd0);
    end
    req_valid = 1'b1; req_we = 4'b0000; req_addr = 10'd4; req_tag = 5'd24;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready_low", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_same_cycle", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    send(4'b0000, 10'd4, 32'h0, 5'd24, sval(4), 1'b0, 1'b0);
    check("bp_ready_next_cycle", 64'(last_wait), 64'd0);
    send(4'b0000, 10'd5, 32'h0, 5'd25, sval(5), 1'b0, 1'b0);
    drain("bp_drain");

    // Flush squashes in-flight loads, keeps prior store
    rsp_ready = 1'b0;
    send(4'b1111, 10'd20, 32'h5A5A_A5A5, 5'd0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send(4'b0000, 10'd20, 32'h0, 5'(12 + i), 32'h5A5A_A5A5, 1'b0, 1'b0);
    flush = 1'b1;
    rsp_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("flush_rsp_valid", 64'(rsp_valid), 64'd0);
    check("flush_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    check("post_flush_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(4'b0000, 10'd20, 32'h0, 5'(15 + i), 32'h5A5A_A5A5, 1'b0, 1'b0);
      check("flush_credit", 64'(last_wait), 64'd0);
    end
    @(negedge clk);
    check("flush_credits_full", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain("flush_drain");

    // Out-of-range and boundary addresses
    send(4'b1111, 10'd10,   32'h0A0B_0C0D, 5'd0, 32'h0, 1'b0, 1'b0);
    send(4'b1111, 10'd999,  32'h9999_0999, 5'd0, 32'h0, 1'b0, 1'b0);
    send(4'b1111, 10'd1010, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b0, 1'b0);
    send(4'b1111, 10'd1000, 32'h0000_FFFF, 5'd0, 32'h0, 1'b0, 1'b0);
    send(4'b0000, 10'd1010, 32'h0, 5'd7, 32'h0, 1'b1, 1'b1);
    send(4'b0000, 10'd999,  32'h0, 5'd8, 32'h9999_0999, 1'b0, 1'b1);
    send(4'b0000, 10'd1000, 32'h0, 5'd6, 32'h0, 1'b1, 1'b1);
    send(4'b0000, 10'd10,   32'h0, 5'd5, 32'h0A0B_0C0D, 1'b0, 1'b1);
    drain("oor_drain");

    // Reset in the middle of two loads
    send(4'b1111, 10'd30, 32'h1234_5678, 5'd0, 32'h0, 1'b0, 1'b0);
    rsp_ready = 1'b0;
    send(4'b0000, 10'd30, 32'h0, 5'd9,  32'h1234_5678, 1'b0, 1'b0);
    send(4'b0000, 10'd30, 32'h0, 5'd10, 32'h1234_5678, 1'b0, 1'b0);
    check("rst_pre_valid", 64'(rsp_valid), 64'd1);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_valid", 64'(rsp_valid), 64'd0);
    check("rst_mid_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_mid_tag",   64'(rsp_tag),   64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_rel_ready", 64'(req_ready), 64'd1);
    check("rst_rel_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send(4'b0000, 10'd30, 32'h0, 5'd11, 32'h1234_5678, 1'b0, 1'b1);
    drain("rst_drain");

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
